// File: rtl/i2c_csr_core.sv
// ============================================================================
// Module      : i2c_csr_core
// Description : CSR bank, command FIFO and receive FIFO sitting between the
//               AXI-lite BRAM-style strobes and the I2C bit engine.
//               Define I2C_CSR_IRQ_EN to build the registered interrupt logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_csr_core #(
  parameter int          ADD_WIDTH    = 8,
  parameter int          CMD_DEPTH    = 4,
  parameter int          RX_DEPTH     = 4,
  parameter logic [15:0] PRESCALE_RST = 16'h00FF
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ADD_WIDTH-1:0] bram_addr,
  input  logic                 bram_wr,
  input  logic [31:0]          bram_wr_data,
  input  logic                 bram_rd,
  output logic [31:0]          bram_rd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [11:0]          cmd_data,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 core_busy,
  input  logic                 core_nack,
  output logic [15:0]          prescale,
  output logic                 irq
);

  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int IDX_W  = ADD_WIDTH - 2;

  localparam logic [IDX_W-1:0] c_IDX_CTRL = IDX_W'(0);
  localparam logic [IDX_W-1:0] c_IDX_STAT = IDX_W'(1);
  localparam logic [IDX_W-1:0] c_IDX_PRE  = IDX_W'(2);
  localparam logic [IDX_W-1:0] c_IDX_CMD  = IDX_W'(3);
  localparam logic [IDX_W-1:0] c_IDX_RX   = IDX_W'(4);

  logic [IDX_W-1:0] w_idx;
  logic             w_wr_ctrl, w_wr_stat, w_wr_pre, w_wr_cmd, w_rd_rx, w_flush;
  logic             w_irq_en;
  logic             w_unused;

  logic             en_q, en_d;
  logic [15:0]      prescale_q, prescale_d;
  logic             nack_q, nack_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic             cmd_ovf_q, cmd_ovf_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      w_rd_val;

  logic [11:0]      cmd_mem_q [CMD_DEPTH];
  logic [CMD_AW:0]  cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic             w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

  assign w_idx     = bram_addr[ADD_WIDTH-1:2];
  assign w_wr_ctrl = bram_wr && (w_idx == c_IDX_CTRL);
  assign w_wr_stat = bram_wr && (w_idx == c_IDX_STAT);
  assign w_wr_pre  = bram_wr && (w_idx == c_IDX_PRE);
  assign w_wr_cmd  = bram_wr && (w_idx == c_IDX_CMD);
  assign w_rd_rx   = bram_rd && (w_idx == c_IDX_RX);
  assign w_flush   = w_wr_ctrl && bram_wr_data[2];
  assign w_unused  = ^{bram_wr_data[31:16], bram_wr_data[1], bram_addr[1:0]};

  // Full when the wrap bits differ and the index bits match.
  assign w_cmd_empty = (cmd_wr_q == cmd_rd_q);
  assign w_cmd_full  = (cmd_wr_q[CMD_AW] != cmd_rd_q[CMD_AW]) &&
                       (cmd_wr_q[CMD_AW-1:0] == cmd_rd_q[CMD_AW-1:0]);
  assign w_rx_empty  = (rx_wr_q == rx_rd_q);
  assign w_rx_full   = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                       (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

  assign cmd_valid = en_q && !w_cmd_empty;
  assign cmd_data  = cmd_mem_q[cmd_rd_q[CMD_AW-1:0]];
  assign w_cmd_pop = cmd_valid && cmd_ready;
  assign w_cmd_push = w_wr_cmd && (!w_cmd_full || w_cmd_pop);

  assign w_rx_pop  = w_rd_rx && !w_rx_empty;
  assign w_rx_push = rx_valid && (!w_rx_full || w_rx_pop);

  assign bram_rd_data = rd_data_q;
  assign prescale     = prescale_q;

  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_rd_d   = cmd_rd_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;

    if (w_wr_ctrl) en_d = bram_wr_data[0];
    if (w_wr_pre)  prescale_d = bram_wr_data[15:0];

    // Flush wins over any push/pop landing in the same cycle.
    if (w_flush) begin
      cmd_wr_d = '0;
      cmd_rd_d = '0;
      rx_wr_d  = '0;
      rx_rd_d  = '0;
    end else begin
      if (w_cmd_push) cmd_wr_d = cmd_wr_q + (CMD_AW+1)'(1);
      if (w_cmd_pop)  cmd_rd_d = cmd_rd_q + (CMD_AW+1)'(1);
      if (w_rx_push)  rx_wr_d  = rx_wr_q + (RX_AW+1)'(1);
      if (w_rx_pop)   rx_rd_d  = rx_rd_q + (RX_AW+1)'(1);
    end

    // Sticky bits: a new event beats a write-1-to-clear in the same cycle.
    nack_d    = core_nack || (nack_q && !(w_wr_stat && bram_wr_data[5]));
    rx_ovf_d  = (rx_valid && w_rx_full && !w_rx_pop && !w_flush) ||
                (rx_ovf_q && !(w_wr_stat && bram_wr_data[6]));
    cmd_ovf_d = (w_wr_cmd && w_cmd_full && !w_cmd_pop) ||
                (cmd_ovf_q && !(w_wr_stat && bram_wr_data[7]));
  end

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      c_IDX_CTRL: w_rd_val = {30'b0, w_irq_en, en_q};
      c_IDX_STAT: w_rd_val = {24'b0, cmd_ovf_q, rx_ovf_q, nack_q, core_busy,
                              w_rx_full, w_rx_empty, w_cmd_empty, w_cmd_full};
      c_IDX_PRE:  w_rd_val = {16'b0, prescale_q};
      c_IDX_RX:   if (!w_rx_empty) w_rd_val = {23'b0, 1'b1, rx_mem_q[rx_rd_q[RX_AW-1:0]]};
      default:    w_rd_val = '0;
    endcase
    rd_data_d = bram_rd ? w_rd_val : rd_data_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
      nack_q     <= 1'b0;
      rx_ovf_q   <= 1'b0;
      cmd_ovf_q  <= 1'b0;
      rd_data_q  <= '0;
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      nack_q     <= nack_d;
      rx_ovf_q   <= rx_ovf_d;
      cmd_ovf_q  <= cmd_ovf_d;
      rd_data_q  <= rd_data_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (w_cmd_push) cmd_mem_q[cmd_wr_q[CMD_AW-1:0]] <= bram_wr_data[11:0];
    if (w_rx_push)  rx_mem_q[rx_wr_q[RX_AW-1:0]]    <= rx_data;
  end

`ifdef I2C_CSR_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  // Built from next-state values so irq lands the cycle after its cause.
  always_comb begin
    irq_en_d = irq_en_q;
    if (w_wr_ctrl) irq_en_d = bram_wr_data[1];
    irq_d = irq_en_d && ((rx_wr_d != rx_rd_d) || nack_d || rx_ovf_d || cmd_ovf_d);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign w_irq_en = irq_en_q;
  assign irq      = irq_q;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_csr_core.sv
// ============================================================================
// Module      : tb_i2c_csr_core
// Description : Self-checking bench for i2c_csr_core (queue-based reference).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_csr_core;

  localparam int CMDD = 4;
  localparam int RXD  = 4;

  logic        aclk, aresetn;
  logic [7:0]  bram_addr;
  logic        bram_wr, bram_rd;
  logic [31:0] bram_wr_data;
  logic [31:0] bram_rd_data;
  logic        cmd_valid, cmd_ready;
  logic [11:0] cmd_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        core_busy, core_nack;
  logic [15:0] prescale;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_csr_core #(
    .ADD_WIDTH(8), .CMD_DEPTH(CMDD), .RX_DEPTH(RXD), .PRESCALE_RST(16'h00FF)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .bram_addr(bram_addr), .bram_wr(bram_wr), .bram_wr_data(bram_wr_data),
    .bram_rd(bram_rd), .bram_rd_data(bram_rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .core_busy(core_busy), .core_nack(core_nack),
    .prescale(prescale), .irq(irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference state: registers as plain values, FIFOs as queues.
  bit        m_en, m_irq_en, m_nack, m_rxovf, m_cmdovf;
  bit [15:0] m_prescale;
  bit [31:0] m_rd;
  bit [11:0] cmdq[$];
  bit [7:0]  rxq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_nack = 0; m_rxovf = 0; m_cmdovf = 0;
    m_prescale = 16'h00FF; m_rd = 0;
    cmdq.delete(); rxq.delete();
  endtask

  function automatic bit exp_irq();
`ifdef I2C_CSR_IRQ_EN
    return m_irq_en && (rxq.size() > 0 || m_nack || m_rxovf || m_cmdovf);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int  idx = int'(bram_addr[7:2]);
    int  csz = cmdq.size();
    int  rsz = rxq.size();
    bit  cpop, rpop, flush, wst, cevt, revt;
    cevt = 0; revt = 0;
    if (bram_rd) begin
      case (idx)
        0: m_rd = {30'b0, m_irq_en, m_en};
        1: m_rd = {24'b0, m_cmdovf, m_rxovf, m_nack, core_busy,
                   rsz == RXD, rsz == 0, csz == 0, csz == CMDD};
        2: m_rd = {16'b0, m_prescale};
        4: m_rd = (rsz > 0) ? {23'b0, 1'b1, rxq[0]} : 32'h0;
        default: m_rd = 32'h0;
      endcase
    end
    cpop  = m_en && csz > 0 && cmd_ready;
    rpop  = bram_rd && idx == 4 && rsz > 0;
    flush = bram_wr && idx == 0 && bram_wr_data[2];
    wst   = bram_wr && idx == 1;
    if (flush) begin
      cmdq.delete(); rxq.delete();
    end else begin
      if (cpop) void'(cmdq.pop_front());
      if (bram_wr && idx == 3) begin
        if (csz < CMDD || cpop) cmdq.push_back(bram_wr_data[11:0]);
        else cevt = 1;
      end
      if (rpop) void'(rxq.pop_front());
      if (rx_valid) begin
        if (rsz < RXD || rpop) rxq.push_back(rx_data);
        else revt = 1;
      end
    end
    m_nack   = core_nack || (m_nack && !(wst && bram_wr_data[5]));
    m_rxovf  = revt || (m_rxovf && !(wst && bram_wr_data[6]));
    m_cmdovf = cevt || (m_cmdovf && !(wst && bram_wr_data[7]));
    if (bram_wr && idx == 0) begin
      m_en = bram_wr_data[0];
`ifdef I2C_CSR_IRQ_EN
      m_irq_en = bram_wr_data[1];
`endif
    end
    if (bram_wr && idx == 2) m_prescale = bram_wr_data[15:0];
  endtask

  always @(posedge aclk) if (aresetn) model_step();

  // Continuous comparison against the reference, away from the active edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      bit cv;
      cv = m_en && cmdq.size() > 0;
      chk("cmd_valid", {31'b0, cmd_valid}, {31'b0, cv});
      if (cv) chk("cmd_data", {20'b0, cmd_data}, {20'b0, cmdq[0]});
      chk("prescale", {16'b0, prescale}, {16'b0, m_prescale});
      chk("irq", {31'b0, irq}, {31'b0, exp_irq()});
      chk("bram_rd_data", bram_rd_data, m_rd);
    end
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bram_addr = a; bram_wr_data = d; bram_wr = 1'b1;
    tick();
    bram_wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    bram_addr = a; bram_rd = 1'b1;
    tick();
    bram_rd = 1'b0;
    chk(name, bram_rd_data, exp);
  endtask

  task automatic idle_inputs();
    bram_wr = 0; bram_rd = 0; bram_addr = 0; bram_wr_data = 0;
    cmd_ready = 0; rx_valid = 0; rx_data = 0; core_busy = 0; core_nack = 0;
  endtask

  initial begin
    int hs;
    idle_inputs();
    aresetn = 1'b0;
    model_reset();
    repeat (3) tick();
    aresetn = 1'b1;

    // Reset state
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_rd_data", bram_rd_data, 32'h0);
    chk("rst_prescale", {16'b0, prescale}, 32'h00FF);
    rd_chk("rst_PRESCALE", 8'h08, 32'h0000_00FF);
    rd_chk("rst_STAT", 8'h04, 32'h0000_0006);

    // Command FIFO fill, overflow, then drain
    wr(8'h00, 32'h1);
    repeat (4) wr(8'h0C, 32'h1A5);
    rd_chk("STAT_cmd_full", 8'h04, 32'h0000_0005);
    wr(8'h0C, 32'h1A5);
    rd_chk("STAT_cmd_ovf", 8'h04, 32'h0000_0085);
    cmd_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid) begin
        hs++;
        chk("hs_cmd_data", {20'b0, cmd_data}, 32'h1A5);
      end
      tick();
    end
    chk("hs_count", hs, 4);
    chk("drained_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    cmd_ready = 1'b0;
    wr(8'h04, 32'h80);

    // RX buffering
    rx_valid = 1; rx_data = 8'h11; tick();
    rx_data = 8'h22; tick();
    rx_valid = 0;
    rd_chk("RX_0x11", 8'h10, 32'h111);
    rd_chk("RX_0x22", 8'h10, 32'h122);
    rd_chk("RX_empty", 8'h10, 32'h000);

    // RX overflow and W1C
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1; rx_data = 8'(8'h30 + i); tick();
    end
    rx_valid = 0;
    rd_chk("STAT_rx_ovf", 8'h04, 32'h0000_004A);
    wr(8'h04, 32'h40);
    rd_chk("STAT_rx_ovf_clr", 8'h04, 32'h0000_000A);

    // Flush with queued commands
    wr(8'h0C, 32'h301);
    wr(8'h0C, 32'h302);
    wr(8'h00, 32'h5);
    chk("flush_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    rd_chk("STAT_flushed", 8'h04, 32'h0000_0006);
    rd_chk("CTRL_after_flush", 8'h00, 32'h1);

    // NACK sticky and interrupt
    wr(8'h00, 32'h3);
`ifdef I2C_CSR_IRQ_EN
    rd_chk("CTRL_irq_en", 8'h00, 32'h3);
`else
    rd_chk("CTRL_irq_en", 8'h00, 32'h1);
`endif
    chk("irq_quiet", {31'b0, irq}, 32'h0);
    core_nack = 1; tick(); core_nack = 0;
`ifdef I2C_CSR_IRQ_EN
    chk("irq_on_nack", {31'b0, irq}, 32'h1);
`else
    chk("irq_on_nack", {31'b0, irq}, 32'h0);
`endif
    rd_chk("STAT_nack", 8'h04, 32'h0000_0026);
    wr(8'h04, 32'h20);
    chk("irq_after_w1c", {31'b0, irq}, 32'h0);

    // Randomised traffic with one asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r, w;
      logic [31:0] d;
      if (cyc == 1500) begin
        idle_inputs();
        aresetn = 1'b0;
        model_reset();
        tick(); tick();
        aresetn = 1'b1;
      end
      bram_wr = 0; bram_rd = 0;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        w = $urandom_range(0, 9);
        if (w > 5) w = 3;
        d = $urandom;
        if (w == 0 && $urandom_range(0, 7) != 0) d[2] = 1'b0;
        bram_addr = 8'(w * 4 + $urandom_range(0, 3));
        bram_wr_data = d;
        bram_wr = 1;
      end else if (r < 55) begin
        w = $urandom_range(0, 7);
        if (w > 5) w = 4;
        bram_addr = (w == 5) ? 8'($urandom_range(20, 255)) : 8'(w * 4);
        bram_rd = 1;
      end
      rx_valid  = ($urandom_range(0, 99) < 30);
      rx_data   = 8'($urandom);
      cmd_ready = 1'($urandom);
      core_nack = ($urandom_range(0, 99) < 5);
      core_busy = 1'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
